// File: rtl/sysray_seq.sv
// Tile sequencer and input skewer for an N x N systolic array: accepts K beats per
// tile, delays lane i by i+1 cycles into a diagonal wavefront, then drains and pulses done.
module sysray_seq #(
    parameter int N      = 2,
    parameter int DATA_W = 16,
    parameter int K_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [K_W-1:0]      k_len_i,
    input  logic                beat_valid_i,
    output logic                beat_ready_o,
    input  logic [N*DATA_W-1:0] beat_data_i,
    input  logic [N*DATA_W-1:0] beat_weight_i,
    output logic [N*DATA_W-1:0] sysdata_o,
    output logic [N*DATA_W-1:0] sysweight_o,
    output logic [N-1:0]        valid_input_o,
    output logic [N-1:0]        valid_weight_o,
    output logic                busy_o,
    output logic                done_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, FEED = 2'd1, DRAIN = 2'd2} state_t;

    localparam int              DR_W    = $clog2(3 * N);
    localparam logic [DR_W-1:0] DR_LAST = DR_W'(3 * N - 3);

    state_t          state_q, state_d;
    logic [K_W-1:0]  k_len_q, k_len_d;
    logic [K_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [DR_W-1:0] drain_cnt_q, drain_cnt_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            accept_s;

    assign beat_ready_o = (state_q == FEED);
    assign accept_s     = beat_valid_i && beat_ready_o;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

    // Next-state logic; done is raised on the edge that enters the final drain count.
    always_comb begin
        state_d     = state_q;
        k_len_d     = k_len_q;
        beat_cnt_d  = beat_cnt_q;
        drain_cnt_d = drain_cnt_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (k_len_i != {K_W{1'b0}}) begin
                        state_d    = FEED;
                        k_len_d    = k_len_i;
                        beat_cnt_d = {K_W{1'b0}};
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            FEED: begin
                if (accept_s) begin
                    if (beat_cnt_q == k_len_q - K_W'(1)) begin
                        state_d     = DRAIN;
                        drain_cnt_d = {DR_W{1'b0}};
                        done_d      = (DR_LAST == {DR_W{1'b0}});
                    end else begin
                        beat_cnt_d = beat_cnt_q + K_W'(1);
                    end
                end else begin
                    beat_cnt_d = beat_cnt_q;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == DR_LAST) begin
                    state_d = IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q + DR_W'(1);
                    done_d      = ((drain_cnt_q + DR_W'(1)) == DR_LAST);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            k_len_q     <= {K_W{1'b0}};
            beat_cnt_q  <= {K_W{1'b0}};
            drain_cnt_q <= {DR_W{1'b0}};
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_len_q     <= k_len_d;
            beat_cnt_q  <= beat_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        // Each stage holds {valid, value}; non-accepted slots carry all zeros.
        logic [DATA_W:0] dat_sk_q [0:i];
        logic [DATA_W:0] dat_sk_d [0:i];
        logic [DATA_W:0] wgt_sk_q [0:i];
        logic [DATA_W:0] wgt_sk_d [0:i];

        // Stage 0 load and shift along the lane.
        always_comb begin
            if (accept_s) begin
                dat_sk_d[0] = {1'b1, beat_data_i[i*DATA_W +: DATA_W]};
                wgt_sk_d[0] = {1'b1, beat_weight_i[i*DATA_W +: DATA_W]};
            end else begin
                dat_sk_d[0] = {(DATA_W+1){1'b0}};
                wgt_sk_d[0] = {(DATA_W+1){1'b0}};
            end
            for (int s = 1; s <= i; s++) begin
                dat_sk_d[s] = dat_sk_q[s-1];
                wgt_sk_d[s] = wgt_sk_q[s-1];
            end
        end

        // Skew registers.
        always_ff @(posedge clk) begin
            for (int s = 0; s <= i; s++) begin
                if (rst) begin
                    dat_sk_q[s] <= {(DATA_W+1){1'b0}};
                    wgt_sk_q[s] <= {(DATA_W+1){1'b0}};
                end else begin
                    dat_sk_q[s] <= dat_sk_d[s];
                    wgt_sk_q[s] <= wgt_sk_d[s];
                end
            end
        end

        assign sysdata_o[i*DATA_W +: DATA_W]   = dat_sk_q[i][DATA_W-1:0];
        assign sysweight_o[i*DATA_W +: DATA_W] = wgt_sk_q[i][DATA_W-1:0];
        assign valid_input_o[i]                = dat_sk_q[i][DATA_W];
        assign valid_weight_o[i]               = wgt_sk_q[i][DATA_W];
    end

endmodule

// File: tb/tb_sysray_seq.sv
// Randomized bench for sysray_seq against a timestamp-based reference model.
module tb_sysray_seq;

    localparam int N    = 2;
    localparam int DW   = 16;
    localparam int KW   = 16;
    localparam int VW   = N * DW;
    localparam int MAXC = 4096;

    logic          clk = 1'b0;
    logic          rst, start_i, beat_valid_i;
    logic [KW-1:0] k_len_i;
    logic [VW-1:0] beat_data_i, beat_weight_i;
    logic          beat_ready_o, busy_o, done_o;
    logic [VW-1:0] sysdata_o, sysweight_o;
    logic [N-1:0]  valid_input_o, valid_weight_o;

    sysray_seq #(.N(N), .DATA_W(DW), .K_W(KW)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .k_len_i(k_len_i),
        .beat_valid_i(beat_valid_i), .beat_ready_o(beat_ready_o),
        .beat_data_i(beat_data_i), .beat_weight_i(beat_weight_i),
        .sysdata_o(sysdata_o), .sysweight_o(sysweight_o),
        .valid_input_o(valid_input_o), .valid_weight_o(valid_weight_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: tile described by timestamps; accepted beats logged by cycle.
    bit          in_tile;
    int          feed_from, beats_left, free_at, done_at;
    bit          hist_v [MAXC];
    logic [VW-1:0] hist_d [MAXC];
    logic [VW-1:0] hist_w [MAXC];
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit exp_ready(input int c);
        return in_tile && c >= feed_from && beats_left > 0;
    endfunction

    function automatic bit exp_busy(input int c);
        return in_tile && c >= feed_from && c < free_at;
    endfunction

    function automatic logic [VW-1:0] exp_vec(input bit wt, input int c);
        logic [VW-1:0] r = '0;
        for (int i = 0; i < N; i++) begin
            int idx = c - 1 - i;
            if (idx >= 0 && hist_v[idx])
                r[i*DW +: DW] = wt ? hist_w[idx][i*DW +: DW] : hist_d[idx][i*DW +: DW];
        end
        return r;
    endfunction

    function automatic logic [N-1:0] exp_val(input int c);
        logic [N-1:0] r = '0;
        for (int i = 0; i < N; i++) begin
            int idx = c - 1 - i;
            if (idx >= 0 && hist_v[idx]) r[i] = 1'b1;
        end
        return r;
    endfunction

    task automatic tick(input logic r, input logic s, input logic [KW-1:0] k, input logic v);
        logic [VW-1:0] d, w;
        @(negedge clk);
        if (cyc >= MAXC - 1) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC - 1);
            $fatal(1, "cycle budget exceeded");
        end
        if (cyc >= 1) begin
            check_eq("ready",   64'(beat_ready_o),   64'(exp_ready(cyc)));
            check_eq("busy",    64'(busy_o),         64'(exp_busy(cyc)));
            check_eq("done",    64'(done_o),         64'(cyc == done_at));
            check_eq("sysdata", 64'(sysdata_o),      64'(exp_vec(1'b0, cyc)));
            check_eq("sysweight", 64'(sysweight_o),  64'(exp_vec(1'b1, cyc)));
            check_eq("vin",     64'(valid_input_o),  64'(exp_val(cyc)));
            check_eq("vwt",     64'(valid_weight_o), 64'(exp_val(cyc)));
        end
        for (int i = 0; i < N; i++) begin
            d[i*DW +: DW] = DW'($urandom);
            w[i*DW +: DW] = DW'($urandom);
        end
        rst = r; start_i = s; k_len_i = k; beat_valid_i = v;
        beat_data_i = d; beat_weight_i = w;
        if (r) begin
            in_tile = 1'b0;
            done_at = -1;
            for (int x = (cyc > N ? cyc - N : 0); x <= cyc; x++) hist_v[x] = 1'b0;
        end else if (exp_ready(cyc) && v) begin
            hist_v[cyc] = 1'b1;
            hist_d[cyc] = d;
            hist_w[cyc] = w;
            beats_left--;
            if (beats_left == 0) begin
                done_at = cyc + 3 * N - 2;
                free_at = cyc + 3 * N - 1;
            end
        end else if (!exp_busy(cyc) && s) begin
            if (k == '0) begin
                done_at = cyc + 1;
            end else begin
                in_tile    = 1'b1;
                feed_from  = cyc + 1;
                beats_left = int'(k);
                free_at    = 1 << 30;
            end
        end
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; k_len_i = '0; beat_valid_i = 1'b0;
        beat_data_i = '0; beat_weight_i = '0;
        in_tile = 1'b0; feed_from = 0; beats_left = 0; free_at = 0; done_at = -1;

        // Reset for three cycles, then quiet idle.
        tick(1'b1, 1'b0, 16'd0, 1'b0);
        tick(1'b1, 1'b0, 16'd0, 1'b0);
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 16'd0, 1'b0);

        // k_len=3 with valid held high; extra valids after the tile must be ignored.
        tick(1'b0, 1'b1, 16'd3, 1'b0);
        for (int i = 0; i < 12; i++) tick(1'b0, 1'b0, 16'd0, 1'b1);
        tick(1'b0, 1'b0, 16'd0, 1'b0);

        // Bubble in the middle of a k_len=2 tile.
        tick(1'b0, 1'b1, 16'd2, 1'b0);
        tick(1'b0, 1'b0, 16'd0, 1'b1);
        tick(1'b0, 1'b0, 16'd0, 1'b0);
        tick(1'b0, 1'b0, 16'd0, 1'b1);
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 16'd0, 1'b0);

        // Zero-length tile.
        tick(1'b0, 1'b1, 16'd0, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 16'd0, 1'b0);

        // Starts during FEED and DRAIN are ignored.
        tick(1'b0, 1'b1, 16'd4, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 16'd7, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 16'd5, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 16'd0, 1'b0);

        // Reset mid-FEED after one beat, then a fresh single-beat tile.
        tick(1'b0, 1'b1, 16'd4, 1'b0);
        tick(1'b0, 1'b0, 16'd0, 1'b1);
        tick(1'b1, 1'b0, 16'd0, 1'b1);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 16'd0, 1'b0);
        tick(1'b0, 1'b1, 16'd1, 1'b0);
        tick(1'b0, 1'b0, 16'd0, 1'b1);
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 16'd0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 1500; i++)
            tick($urandom_range(0, 149) == 0, $urandom_range(0, 5) == 0,
                 KW'($urandom_range(0, 6)), $urandom_range(0, 9) < 7);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 16'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
